// File: rtl/bus_pkg.sv
// Shared types and default memory map for the CPU-to-peripheral bus controller.
// Imported by the decoder and the controller top.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Default MIPS SoC map: RAM (16 KiB), VRAM (64 KiB, byte-wide), IO (256 B).
  localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hFFFF_C000;
  localparam logic [31:0] VRAM_BASE = 32'hF000_0000;
  localparam logic [31:0] VRAM_MASK = 32'hFFFF_0000;
  localparam logic [31:0] IO_BASE   = 32'hF001_0000;
  localparam logic [31:0] IO_MASK   = 32'hFFFF_FF00;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_ctrl_if.sv
// CPU memory port plus the fan-out to the slave regions, bundled as one interface.
// master = controller view, slave = CPU and peripherals view.
interface bus_ctrl_if #(
  parameter int NUM_SLV = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);

  logic                      cpu_req;
  logic                      cpu_we;
  logic [ADDR_W-1:0]         cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_ready;
  logic                      cpu_err;
  logic [NUM_SLV-1:0]        slv_sel;
  logic [NUM_SLV-1:0]        slv_we;
  logic [ADDR_W-1:0]         slv_addr;
  logic [DATA_W-1:0]         slv_wdata;
  logic [NUM_SLV*DATA_W-1:0] slv_rdata;
  logic [NUM_SLV-1:0]        slv_ack;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    output cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, slv_rdata, slv_ack,
    input  cpu_rdata, cpu_ready, cpu_err, slv_sel, slv_we, slv_addr, slv_wdata
  );

endinterface

// File: rtl/bus_decode.sv
// Combinational priority address decoder: region i hits when (addr & mask) == base,
// and the lowest hitting index wins.
module bus_decode #(
  parameter int                        NUM_SLV  = 3,
  parameter int                        ADDR_W   = 32,
  parameter int                        IDX_W    = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Walk from the highest index down so the lowest hitting region is written last.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_ctrl.sv
// Registered CPU-to-peripheral bus controller: decodes, runs a req/ack handshake per slave,
// narrows byte-wide slaves, and reports bus errors for unmapped or timed-out accesses.
module bus_ctrl
  import bus_pkg::*;
#(
  parameter int                        NUM_SLV    = 3,
  parameter int                        ADDR_W     = 32,
  parameter int                        DATA_W     = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE   = {IO_BASE, VRAM_BASE, RAM_BASE},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK   = {IO_MASK, VRAM_MASK, RAM_MASK},
  parameter logic [NUM_SLV-1:0]        SLV_NARROW = 3'b010,
  parameter int                        TIMEOUT    = 16
) (
  input logic       clk,
  input logic       rst_n,
  bus_ctrl_if.master bus
);

  localparam int               IDX_W    = cnt_width(NUM_SLV);
  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q,   idx_d;
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [NUM_SLV-1:0]  sel_q,   sel_d;
  logic [NUM_SLV-1:0]  swe_q,   swe_d;
  logic                we_q,    we_d;
  logic                err_q,   err_d;

  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [DATA_W-1:0]   sel_rdata;

  bus_decode #(
    .NUM_SLV  (NUM_SLV),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr_i (bus.cpu_addr),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  function automatic logic [DATA_W-1:0] zext8(input logic [DATA_W-1:0] d);
    return {{(DATA_W-8){1'b0}}, d[7:0]};
  endfunction

  assign sel_rdata = bus.slv_rdata[int'(idx_q)*DATA_W +: DATA_W];

  always_comb begin
    // NOTE: every _d takes its _q value first, so no branch leaves one unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    swe_d   = swe_q;
    we_d    = we_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (dec_hit) begin
            idx_d   = dec_idx;
            addr_d  = bus.cpu_addr & ~SLV_MASK[int'(dec_idx)*ADDR_W +: ADDR_W];
            wdata_d = SLV_NARROW[dec_idx] ? zext8(bus.cpu_wdata) : bus.cpu_wdata;
            we_d    = bus.cpu_we;
            cnt_d   = '0;
            sel_d   = NUM_SLV'(1) << dec_idx;
            swe_d   = bus.cpu_we ? (NUM_SLV'(1) << dec_idx) : '0;
            state_d = ACCESS;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end

      ACCESS: begin
        // Ack is checked before the timeout, so an ack on the last cycle still succeeds.
        if (bus.slv_ack[idx_q]) begin
          if (we_q)                   rdata_d = '0;
          else if (SLV_NARROW[idx_q]) rdata_d = zext8(sel_rdata);
          else                        rdata_d = sel_rdata;
          err_d   = 1'b0;
          sel_d   = '0;
          swe_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          sel_d   = '0;
          swe_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      swe_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      swe_q   <= swe_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign bus.cpu_ready = (state_q == DONE);
  assign bus.cpu_rdata = bus.cpu_ready ? rdata_q : '0;
  assign bus.cpu_err   = bus.cpu_ready & err_q;
  assign bus.slv_sel   = sel_q;
  assign bus.slv_we    = swe_q;
  assign bus.slv_addr  = addr_q;
  assign bus.slv_wdata = wdata_q;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: decode, narrow slaves, wait states, unmapped and timeout
// errors, foreign acks and asynchronous reset abort.
module tb_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  bus_ctrl_if #(.NUM_SLV(3), .ADDR_W(32), .DATA_W(32)) bus ();

  bus_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives req for one cycle from the current falling edge; returns one cycle later with req low.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    tick();
    bus.cpu_req   = 1'b0;
  endtask

  task automatic set_rdata(input int slot, input logic [31:0] val);
    bus.slv_rdata[slot*32 +: 32] = val;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.slv_rdata = '0;
    bus.slv_ack   = '0;
    tick(); tick();

    check("rst_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_err",   32'(bus.cpu_err),   32'd0);
    check("rst_rdata", bus.cpu_rdata,      32'd0);
    check("rst_sel",   32'(bus.slv_sel),   32'd0);
    check("rst_we",    32'(bus.slv_we),    32'd0);
    check("rst_addr",  bus.slv_addr,       32'd0);
    check("rst_wdata", bus.slv_wdata,      32'd0);
    rst_n = 1'b1;
    tick();

    // RAM read, zero wait
    issue(1'b0, 32'h0000_0104, 32'h0);
    check("ram_rd_sel",   32'(bus.slv_sel),   32'h1);
    check("ram_rd_we",    32'(bus.slv_we),    32'h0);
    check("ram_rd_addr",  bus.slv_addr,       32'h104);
    check("ram_rd_busy",  32'(bus.cpu_ready), 32'd0);
    set_rdata(0, 32'hDEAD_BEEF);
    bus.slv_ack = 3'b001;
    tick();
    bus.slv_ack = 3'b000;
    check("ram_rd_ready", 32'(bus.cpu_ready), 32'd1);
    check("ram_rd_data",  bus.cpu_rdata,      32'hDEAD_BEEF);
    check("ram_rd_err",   32'(bus.cpu_err),   32'd0);
    check("ram_rd_sel_done", 32'(bus.slv_sel), 32'd0);
    tick();
    check("ram_rd_ready_off", 32'(bus.cpu_ready), 32'd0);
    check("ram_rd_data_off",  bus.cpu_rdata,      32'd0);

    // VRAM narrow write
    issue(1'b1, 32'hF000_0010, 32'h1234_56AB);
    check("vram_wr_sel",   32'(bus.slv_sel), 32'h2);
    check("vram_wr_we",    32'(bus.slv_we),  32'h2);
    check("vram_wr_addr",  bus.slv_addr,     32'h10);
    check("vram_wr_wdata", bus.slv_wdata,    32'h0000_00AB);
    bus.slv_ack = 3'b010;
    tick();
    bus.slv_ack = 3'b000;
    check("vram_wr_ready", 32'(bus.cpu_ready), 32'd1);
    check("vram_wr_rdata", bus.cpu_rdata,      32'd0);
    check("vram_wr_err",   32'(bus.cpu_err),   32'd0);
    tick();

    // VRAM narrow read
    issue(1'b0, 32'hF000_0010, 32'h0);
    check("vram_rd_we", 32'(bus.slv_we), 32'h0);
    set_rdata(1, 32'hFFFF_FF5A);
    bus.slv_ack = 3'b010;
    tick();
    bus.slv_ack = 3'b000;
    check("vram_rd_ready", 32'(bus.cpu_ready), 32'd1);
    check("vram_rd_data",  bus.cpu_rdata,      32'h0000_005A);
    tick();

    // IO with five ACCESS cycles, ack on the fifth
    set_rdata(2, 32'hCAFE_0042);
    issue(1'b0, 32'hF001_0004, 32'h0);
    check("io_addr", bus.slv_addr, 32'h4);
    for (int k = 1; k <= 5; k++) begin
      check($sformatf("io_sel_c%0d", k),   32'(bus.slv_sel),   32'h4);
      check($sformatf("io_ready_c%0d", k), 32'(bus.cpu_ready), 32'd0);
      if (k < 5) tick();
    end
    bus.slv_ack = 3'b100;
    tick();
    bus.slv_ack = 3'b000;
    check("io_ready", 32'(bus.cpu_ready), 32'd1);
    check("io_data",  bus.cpu_rdata,      32'hCAFE_0042);
    check("io_err",   32'(bus.cpu_err),   32'd0);
    tick();

    // Unmapped address
    issue(1'b0, 32'h8000_0000, 32'h0);
    check("unmap_sel",   32'(bus.slv_sel),   32'd0);
    check("unmap_ready", 32'(bus.cpu_ready), 32'd1);
    check("unmap_err",   32'(bus.cpu_err),   32'd1);
    check("unmap_data",  bus.cpu_rdata,      32'd0);
    tick();
    check("unmap_ready_off", 32'(bus.cpu_ready), 32'd0);
    check("unmap_err_off",   32'(bus.cpu_err),   32'd0);

    // Timeout: RAM never acks, error 17 cycles after req
    set_rdata(0, 32'h5555_AAAA);
    issue(1'b0, 32'h0000_0040, 32'h0);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("to_ready_c%0d", k), 32'(bus.cpu_ready), 32'd0);
      check($sformatf("to_sel_c%0d", k),   32'(bus.slv_sel),   32'h1);
      tick();
    end
    check("to_ready", 32'(bus.cpu_ready), 32'd1);
    check("to_err",   32'(bus.cpu_err),   32'd1);
    check("to_data",  bus.cpu_rdata,      32'd0);
    tick();

    // Ack on the last timeout cycle wins
    set_rdata(0, 32'h0BAD_F00D);
    issue(1'b0, 32'h0000_0080, 32'h0);
    for (int k = 1; k <= 15; k++) tick();
    check("late_busy", 32'(bus.cpu_ready), 32'd0);
    bus.slv_ack = 3'b001;
    tick();
    bus.slv_ack = 3'b000;
    check("late_ready", 32'(bus.cpu_ready), 32'd1);
    check("late_err",   32'(bus.cpu_err),   32'd0);
    check("late_data",  bus.cpu_rdata,      32'h0BAD_F00D);
    tick();

    // Acks from non-selected slaves are ignored
    set_rdata(0, 32'h1111_0000);
    set_rdata(1, 32'h2222_2222);
    set_rdata(2, 32'h3333_3333);
    issue(1'b0, 32'h0000_0200, 32'h0);
    bus.slv_ack = 3'b110;
    tick();
    check("foreign_ready_c1", 32'(bus.cpu_ready), 32'd0);
    tick();
    check("foreign_ready_c2", 32'(bus.cpu_ready), 32'd0);
    check("foreign_sel",      32'(bus.slv_sel),   32'h1);
    bus.slv_ack = 3'b111;
    tick();
    bus.slv_ack = 3'b000;
    check("foreign_ready", 32'(bus.cpu_ready), 32'd1);
    check("foreign_data",  bus.cpu_rdata,      32'h1111_0000);
    check("foreign_err",   32'(bus.cpu_err),   32'd0);
    tick();

    // Asynchronous reset mid-ACCESS
    issue(1'b1, 32'hF001_0008, 32'h0000_00FF);
    check("arst_sel_pre", 32'(bus.slv_sel), 32'h4);
    check("arst_we_pre",  32'(bus.slv_we),  32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel",   32'(bus.slv_sel),   32'd0);
    check("arst_we",    32'(bus.slv_we),    32'd0);
    check("arst_ready", 32'(bus.cpu_ready), 32'd0);
    tick();
    check("arst_ready_hold", 32'(bus.cpu_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("arst_ready_after", 32'(bus.cpu_ready), 32'd0);
    check("arst_sel_after",   32'(bus.slv_sel),   32'd0);

    set_rdata(0, 32'h7777_0008);
    issue(1'b0, 32'h0000_0008, 32'h0);
    check("post_sel",  32'(bus.slv_sel), 32'h1);
    check("post_addr", bus.slv_addr,     32'h8);
    bus.slv_ack = 3'b001;
    tick();
    bus.slv_ack = 3'b000;
    check("post_ready", 32'(bus.cpu_ready), 32'd1);
    check("post_data",  bus.cpu_rdata,      32'h7777_0008);
    check("post_err",   32'(bus.cpu_err),   32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
Parametrised, registered CPU-to-peripheral bus controller for the MIPS SoC. It is the successor to the combinational RAM/VRAM decoder. It decodes the CPU address against NUM_SLV base/mask regions and runs a req/ready handshake with per-slave acknowledge. It adds narrow (8-bit) slave support, an ack timeout, and a bus-error response for unmapped or timed-out accesses. It sits between the CPU memory port and RAM, VRAM and the IO slaves.

Parameters:
NUM_SLV, 3, number of slave regions (index 0 = highest priority).
ADDR_W, 32, address width.
DATA_W, 32, data width.
SLV_BASE, {32'hF001_0000, 32'hF000_0000, 32'h0000_0000}, packed NUM_SLV*ADDR_W region bases; slave i is at bits [i*ADDR_W +: ADDR_W].
SLV_MASK, {32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_C000}, packed NUM_SLV*ADDR_W decode masks.
SLV_NARROW, 3'b010, bit i = 1 means slave i is 8 bits wide (VRAM by default).
TIMEOUT, 16, number of ACCESS cycles without ack before the access fails with an error; must be at least 2.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cpu_req  in  1  access request; sampled only in IDLE.
cpu_we  in  1  1 = write, 0 = read.
cpu_addr  in  ADDR_W  byte address.
cpu_wdata  in  DATA_W  write data.
cpu_rdata  out  DATA_W  read data; valid while cpu_ready=1.
cpu_ready  out  1  one-cycle completion pulse.
cpu_err  out  1  bus error; qualified by cpu_ready.
slv_sel  out  NUM_SLV  one-hot slave select.
slv_we  out  NUM_SLV  per-slave write strobe.
slv_addr  out  ADDR_W  region offset, equal to the latched cpu_addr & ~SLV_MASK[i].
slv_wdata  out  DATA_W  write data; {24'b0, wdata[7:0]} for narrow slaves.
slv_rdata  in  NUM_SLV*DATA_W  packed slave read data.
slv_ack  in  NUM_SLV  per-slave completion.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
  - All outputs reset to 0; state resets to IDLE; the timeout counter resets to 0.
  - Asserting rst_n mid-access aborts the access immediately: slv_sel and slv_we drop without a clock edge, and no cpu_ready is produced.
- Decode: slave i hits when (cpu_addr & SLV_MASK[i]) == SLV_BASE[i]. If several regions hit, the lowest index wins. If none hits, the access is unmapped.
- State machine: IDLE, ACCESS, DONE.
  - IDLE, cpu_req=0: stay in IDLE.
  - IDLE, cpu_req=1 and a hit: latch idx, addr offset, we and wdata (narrowed if applicable); clear the counter; go to ACCESS.
  - IDLE, cpu_req=1 and unmapped: set err=1 and rdata=0; go to DONE. No slave is selected.
  - ACCESS: slv_sel[idx]=1 and slv_we[idx]=latched we, both registered and stable for the whole state.
    - If slv_ack[idx]=1: capture rdata (zero-extend bits [7:0] for narrow slaves; 0 on writes), set err=0, go to DONE.
    - Else if counter == TIMEOUT-1: set err=1, rdata=0, go to DONE.
    - Else increment the counter.
    - Acks from non-selected slaves are ignored.
  - DONE: cpu_ready=1 for exactly one cycle with cpu_rdata and cpu_err; slv_sel=0; return to IDLE.
- cpu_req is ignored in ACCESS and DONE. The CPU holds req low after ready, or a new access starts in the next IDLE cycle. Back-to-back throughput is therefore one access per 3 cycles minimum.
- Latency:
  - Zero-wait slave (ack in the first ACCESS cycle): cpu_ready 2 cycles after the req edge.
  - Unmapped address: cpu_ready 1 cycle after the req edge.
  - Timeout: cpu_ready TIMEOUT+1 cycles after the req edge.
- Ack arriving in the same cycle the counter reaches TIMEOUT-1: ack wins, no error.
- cpu_rdata, cpu_err and cpu_ready are 0 outside DONE.

Decomposition:
- Package bus_pkg:
  - state enum (IDLE/ACCESS/DONE);
  - default RAM/VRAM/IO base and mask constants;
  - a clog2-based counter-width constant function.
- One sub-module, bus_decode: combinational priority decoder taking addr, SLV_BASE and SLV_MASK, producing hit and idx. Instantiated once in bus_ctrl.

Test Plan:
- RAM read zero-wait: req, addr 0x0000_0104; slave0 acks in the first ACCESS cycle with 0xDEAD_BEEF. Required: slv_addr=0x104; cpu_ready 2 cycles after req; cpu_rdata=0xDEAD_BEEF; err=0.
- VRAM narrow write then read: write 0x1234_56AB to 0xF000_0010 -> slv_wdata=0x0000_00AB, slv_we[1]=1. Then read with slave1 returning 0xFFFF_FF5A -> cpu_rdata=0x0000_005A.
- Wait states: IO at 0xF001_0004, ack after 5 ACCESS cycles. Required: slv_sel[2] held high for 5 cycles; cpu_ready 6 cycles after req.
- Unmapped 0x8000_0000 -> no slv_sel asserted; cpu_ready 1 cycle later with err=1, rdata=0. Timeout: RAM never acks -> err=1 exactly 17 cycles after req (TIMEOUT=16).
- Ack at the last timeout cycle -> err=0. Ack from a non-selected slave -> ignored. rst_n pulsed low mid-ACCESS -> slv_sel drops asynchronously, no cpu_ready, next access completes normally.
